cache_memory_arbiter: RTL and testbench
=======================================

# cache_memory_arbiter

Round-robin arbiter that sits directly downstream of the per-engine instruction caches and shares one instruction memory port among them. Each cache miss port drives a valid/address request; the arbiter serves one miss at a time against a fixed-latency read memory. It returns a one-cycle ready pulse followed by the data on the next cycle, the timing a directly mapped cache expects on its fill path.

## Interface
- N_PORTS, 4: number of cache miss ports, ≥2.
- ADDR_WIDTH, 16: address width, shared with caches and memory.
- DWIDTH, 16: data word width.
- MEM_LATENCY, 1: cycles from `mem_en` to valid `mem_rdata`, ≥1.
- clk  in  1  single clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high; every register clears immediately.
- req_valid  in  N_PORTS  per-port miss request; held with address until that port's ready.
- req_addr  in  N_PORTS*ADDR_WIDTH  port i address at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_ready  out  N_PORTS  one-hot, one-cycle pulse; data follows next cycle.
- req_data  out  DWIDTH  fill data broadcast to all ports.
- mem_en  out  1  memory read strobe, one cycle per access.
- mem_addr  out  ADDR_WIDTH  memory read address.
- mem_rdata  in  DWIDTH  valid exactly MEM_LATENCY cycles after `mem_en`, for one cycle only.
- busy  out  1  high in any state except S_IDLE.

## Operation
- States: S_IDLE, S_ISSUE, S_WAIT, S_DATA. Registers:
  - `grant_idx` (log2 N_PORTS bits)
  - `last_grant`: reset value N_PORTS-1, so port 0 wins first after reset
  - `addr_q` (ADDR_WIDTH)
  - `wait_cnt`: counts 0..MEM_LATENCY-1
- S_IDLE:
  - If any `req_valid`, scan from `last_grant`+1 upward modulo N_PORTS; the first set bit wins.
  - Latch `grant_idx` and `addr_q` from that port, set `last_grant` = winner, go to S_ISSUE.
  - With no request, stay in S_IDLE.
- S_ISSUE: `mem_en`=1, `mem_addr`=`addr_q`, `wait_cnt`←0. If MEM_LATENCY=1, go to S_DATA; else go to S_WAIT.
- S_WAIT: increment `wait_cnt`. Go to S_DATA when the ready pulse has been emitted.
- Ready pulse: `req_ready[grant_idx]`=1 in exactly one cycle, issue cycle + MEM_LATENCY-1:
  - MEM_LATENCY=1: the S_ISSUE cycle.
  - Otherwise: the S_WAIT cycle with `wait_cnt`=MEM_LATENCY-1 (post-increment view).
- S_DATA: `req_data` = `mem_rdata` (combinational pass-through), then go to S_IDLE.
- Outside S_DATA, `req_data` is all zeros.
- Requests arriving while not in S_IDLE wait; they are sampled at the next S_IDLE.
- A requester dropping `req_valid` after grant is a protocol violation. The access still completes, and ready pulses to the latched `grant_idx`.
- Address changes after grant are ignored; `addr_q` is used.
- At most one outstanding memory access; `mem_en` never asserts twice within one transaction.

## Timing
- Reset values: `req_ready`=0, `req_data`=0, `mem_en`=0, `mem_addr`=0, `busy`=0; state S_IDLE.
- Reset mid-transaction aborts the transaction. No ready pulse is produced; the in-flight `mem_rdata` is discarded.
- Request seen in S_IDLE at cycle t:
  - `mem_en` at t+1
  - `req_ready` at t+MEM_LATENCY
  - `req_data` valid at t+MEM_LATENCY+1
  - back in S_IDLE at t+MEM_LATENCY+2
- Throughput: one miss per MEM_LATENCY+2 cycles. The mandatory S_IDLE cycle is the arbitration cycle.
- `req_ready` is never asserted for a port whose request was not granted, and never on two ports at once.
- Fairness: with all ports requesting continuously, grants cycle 0,1,…,N_PORTS-1,0 with no port starved.

## Test plan
- MEM_LATENCY=2, only port 2 requests 0x0123 at t, memory holds 0xBEEF there -> `mem_en`/`mem_addr`=0x0123 at t+1, `req_ready`=4'b0100 at t+2, `req_data`=0xBEEF at t+3, `busy` low at t+4.
- All four ports request from reset, each released after its ready -> grant order 0,1,2,3; every ready one-hot; each port receives its own memory word.
- After port 1 is served, ports 0 and 1 request together -> port 0 granted (scan 2,3,0), then port 1.
- MEM_LATENCY=1, port 3 requests 0x0040 -> ready in the same cycle as `mem_en`, data the next cycle, 3-cycle turnaround.
- Reset asserted in S_WAIT (MEM_LATENCY=3) -> all outputs 0 immediately, no ready pulse. After release, a request on ports 0 and 2 -> port 0 served first.
- Port 1 re-raises `req_valid` with a new address the cycle after its data -> `mem_en` asserts two cycles after data (S_IDLE, S_ISSUE), at the new address.

Source files
------------

// File: rtl/cache_memory_arbiter.sv
// rtl/cache_memory_arbiter.sv - round-robin arbiter sharing one fixed-latency instruction memory among cache miss ports
//
// Purpose: serves one cache miss at a time. The winner is latched in an
// arbitration cycle, the read is issued, a one-cycle ready pulse goes to the
// winner, and the memory word is passed through on the following cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high; clears every register at once
//   req_valid  per-port miss request, held with its address until ready
//   req_addr   port i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_ready  one-hot, one-cycle pulse to the served port
//   req_data   fill data (broadcast), valid the cycle after req_ready, else 0
//   mem_en     memory read strobe, one cycle per access
//   mem_addr   memory read address, driven only with mem_en, else 0
//   mem_rdata  memory data, valid MEM_LATENCY cycles after mem_en
//   busy       high whenever a transaction is in progress
`timescale 1ns/1ps
module cache_memory_arbiter #(
   parameter int N_PORTS     = 4,
   parameter int ADDR_WIDTH  = 16,
   parameter int DWIDTH      = 16,
   parameter int MEM_LATENCY = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_PORTS-1:0]            req_valid,
   input  logic [N_PORTS*ADDR_WIDTH-1:0] req_addr,
   output logic [N_PORTS-1:0]            req_ready,
   output logic [DWIDTH-1:0]             req_data,
   output logic                          mem_en,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   input  logic [DWIDTH-1:0]             mem_rdata,
   output logic                          busy
);

   localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   // Port N_PORTS-1 counts as the previous winner so port 0 wins first.
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_PORTS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DATA
   } state_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
   logic [IDX_W-1:0]       last_grant_q, last_grant_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]       wait_cnt_inc;

   logic [ADDR_WIDTH-1:0]  port_addr [N_PORTS];
   logic                   win_found;
   logic [IDX_W-1:0]       win_idx;
   logic [IDX_W-1:0]       cand_idx;
   logic                   ready_fire;

   always_comb begin
      for (int i = 0; i < N_PORTS; i++) begin
         port_addr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
   end

   // Rotating priority: candidates are visited starting just after the
   // previous winner, wrapping around, so the previous winner is checked last.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand_idx  = '0;
      for (int k = 1; k <= N_PORTS; k++) begin
         cand_idx = IDX_W'((int'(last_grant_q) + k) % N_PORTS);
         if (!win_found && req_valid[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_idx_d  = grant_idx_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      wait_cnt_d   = wait_cnt_q;
      wait_cnt_inc = wait_cnt_q + CNT_W'(1);
      ready_fire   = 1'b0;
      mem_en       = 1'b0;
      mem_addr     = '0;
      req_data     = '0;

      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               grant_idx_d  = win_idx;
               last_grant_d = win_idx;
               addr_d       = port_addr[win_idx];
               state_d      = S_ISSUE;
            end
         end
         S_ISSUE: begin
            mem_en     = 1'b1;
            mem_addr   = addr_q;
            wait_cnt_d = '0;
            // With single-cycle memory the ready pulse shares the issue cycle.
            if (MEM_LATENCY == 1) begin
               ready_fire = 1'b1;
               state_d    = S_DATA;
            end else begin
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            // Ready goes out one cycle ahead of the data, i.e. when the
            // incremented count reaches MEM_LATENCY-1.
            wait_cnt_d = wait_cnt_inc;
            if (wait_cnt_inc == CNT_LAST) begin
               ready_fire = 1'b1;
               state_d    = S_DATA;
            end
         end
         S_DATA: begin
            req_data = mem_rdata;
            state_d  = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign req_ready = ready_fire ? (N_PORTS'(1) << grant_idx_q) : '0;
   assign busy      = (state_q != S_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         grant_idx_q  <= '0;
         last_grant_q <= LAST_RST;
         addr_q       <= '0;
         wait_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         grant_idx_q  <= grant_idx_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         wait_cnt_q   <= wait_cnt_d;
      end
   end

endmodule

// File: tb/tb_cache_memory_arbiter.sv
// tb/tb_cache_memory_arbiter.sv - self-checking bench for cache_memory_arbiter at memory latencies 1, 2 and 3
`timescale 1ns/1ps
module tb_cache_memory_arbiter;

   localparam int NP   = 4;
   localparam int AW   = 16;
   localparam int DW   = 16;
   localparam int NI   = 3;     // instance i has MEM_LATENCY = i+1
   localparam int MAXC = 1024;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [NP-1:0]    rv    [NI];
   logic [NP*AW-1:0] ra    [NI];
   logic [NP-1:0]    rr    [NI];
   logic [DW-1:0]    rd    [NI];
   logic             men   [NI];
   logic [AW-1:0]    maddr [NI];
   logic [DW-1:0]    mrd   [NI];
   logic             bsy   [NI];

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      if (a == 16'h0123) return 16'hBEEF;
      if (a == 16'h0040) return 16'hC0DE;
      return a ^ 16'hA5A5;
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int ML = g + 1;
      logic        pv [ML];
      logic [15:0] pa [ML];
      // Memory: the word for an address strobed in cycle c is presented
      // during cycle c+ML only; otherwise a junk pattern.
      always @(posedge clk) begin
         pv[0] <= men[g];
         pa[0] <= maddr[g];
         for (int i = 1; i < ML; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
         end
      end
      assign mrd[g] = (pv[ML-1] === 1'b1) ? mem_word(pa[ML-1]) : 16'hDEAD;

      cache_memory_arbiter #(
         .N_PORTS(NP), .ADDR_WIDTH(AW), .DWIDTH(DW), .MEM_LATENCY(ML)
      ) u_dut (
         .clk(clk), .reset(reset),
         .req_valid(rv[g]), .req_addr(ra[g]),
         .req_ready(rr[g]), .req_data(rd[g]),
         .mem_en(men[g]), .mem_addr(maddr[g]), .mem_rdata(mrd[g]),
         .busy(bsy[g])
      );
   end

   int n_cmp = 0;
   int n_err = 0;

   // Transaction-level reference: an arbitration decision at cycle t fixes
   // the whole future of that access (strobe, ready, data, busy window).
   int          cyc;
   int          last_w;
   int          next_arb;
   logic        exp_en   [MAXC];
   logic [15:0] exp_addr [MAXC];
   logic [3:0]  exp_rdy  [MAXC];
   logic [15:0] exp_data [MAXC];
   logic        exp_busy [MAXC];

   int          raise_at   [NP];
   logic [15:0] raise_addr [NP];
   bit          rnd;
   int          grant_q [$];
   int          en_cyc_q [$];
   logic [15:0] en_addr_q [$];
   int          en_c, rdy_c, dat_c, idle_c;
   logic [3:0]  rdy_v;
   logic [15:0] dat_v;

   typedef struct {
      int          inst;
      int          port;
      logic [15:0] addr;
      logic [3:0]  rdy;
      logic [15:0] data;
      int          en_off;
      int          rdy_off;
      int          dat_off;
      int          idle_off;
   } vec_t;
   vec_t tbl [3];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      cyc      = 0;
      last_w   = NP - 1;
      next_arb = 0;
      for (int c = 0; c < MAXC; c++) begin
         exp_en[c]   = 1'b0;
         exp_addr[c] = '0;
         exp_rdy[c]  = '0;
         exp_data[c] = '0;
         exp_busy[c] = 1'b0;
      end
      for (int p = 0; p < NP; p++) raise_at[p] = -1;
      grant_q.delete();
      en_cyc_q.delete();
      en_addr_q.delete();
      en_c = -1; rdy_c = -1; dat_c = -1; idle_c = -1;
      rdy_v = '0; dat_v = '0;
   endtask

   task automatic model_step(input int inst);
      int ml;
      int w;
      int p;
      logic [15:0] a;
      ml = inst + 1;
      w  = -1;
      if (cyc >= next_arb && rv[inst] != '0) begin
         for (int k = 1; k <= NP; k++) begin
            p = (last_w + k) % NP;
            if (w < 0 && rv[inst][p]) w = p;
         end
         a = ra[inst][w*AW +: AW];
         if (cyc + ml + 1 < MAXC) begin
            exp_en[cyc+1]      = 1'b1;
            exp_addr[cyc+1]    = a;
            exp_rdy[cyc+ml]    = 4'(1) << w;
            exp_data[cyc+ml+1] = mem_word(a);
            for (int c = cyc + 1; c <= cyc + ml + 1; c++) exp_busy[c] = 1'b1;
         end
         last_w   = w;
         next_arb = cyc + ml + 2;
      end
   endtask

   // One clock: compare outputs, let requesters react, apply new inputs,
   // advance the reference with the inputs the DUT samples at the next edge.
   task automatic cycle(input int inst);
      @(negedge clk);
      check("req_ready", 32'(rr[inst]),    32'(exp_rdy[cyc]));
      check("mem_en",    32'(men[inst]),   32'(exp_en[cyc]));
      check("mem_addr",  32'(maddr[inst]), 32'(exp_addr[cyc]));
      check("req_data",  32'(rd[inst]),    32'(exp_data[cyc]));
      check("busy",      32'(bsy[inst]),   32'(exp_busy[cyc]));
      if (men[inst]) begin
         en_cyc_q.push_back(cyc);
         en_addr_q.push_back(maddr[inst]);
         if (en_c < 0) en_c = cyc;
      end
      if (rr[inst] != '0 && rdy_c < 0) begin rdy_c = cyc; rdy_v = rr[inst]; end
      if (rd[inst] != '0 && dat_c < 0) begin dat_c = cyc; dat_v = rd[inst]; end
      if (!bsy[inst] && en_c >= 0 && cyc > en_c && idle_c < 0) idle_c = cyc;
      for (int p = 0; p < NP; p++) begin
         if (rr[inst][p]) begin
            grant_q.push_back(p);
            rv[inst][p] = 1'b0;
         end
      end
      for (int p = 0; p < NP; p++) begin
         if (raise_at[p] == cyc) begin
            rv[inst][p] = 1'b1;
            ra[inst][p*AW +: AW] = raise_addr[p];
         end
         if (rnd) begin
            if (!rv[inst][p]) begin
               if ($urandom_range(3) == 0) begin
                  rv[inst][p] = 1'b1;
                  ra[inst][p*AW +: AW] = 16'($urandom);
               end
            end else if ($urandom_range(7) == 0) begin
               ra[inst][p*AW +: AW] = 16'($urandom);
            end
         end
      end
      model_step(inst);
      if (cyc < MAXC - 8) cyc++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      for (int i = 0; i < NI; i++) begin
         check("rst_req_ready", 32'(rr[i]),    32'h0);
         check("rst_req_data",  32'(rd[i]),    32'h0);
         check("rst_mem_en",    32'(men[i]),   32'h0);
         check("rst_mem_addr",  32'(maddr[i]), 32'h0);
         check("rst_busy",      32'(bsy[i]),   32'h0);
         rv[i] = '0;
         ra[i] = '0;
      end
      repeat (3) begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) check("rst_no_ready", 32'(rr[i]), 32'h0);
      end
      reset = 1'b0;
      model_reset();
   endtask

   task automatic check_order(input string nm, input int e0, input int e1, input int e2, input int e3, input int n);
      int e [4];
      e = '{e0, e1, e2, e3};
      check({nm, "_count"}, 32'(grant_q.size()), 32'(n));
      for (int k = 0; k < n; k++)
         check(nm, 32'((k < grant_q.size()) ? grant_q[k] : -1), 32'(e[k]));
   endtask

   initial begin
      for (int i = 0; i < NI; i++) begin rv[i] = '0; ra[i] = '0; end
      rnd = 1'b0;
      model_reset();

      tbl[0] = '{1, 2, 16'h0123, 4'b0100, 16'hBEEF, 1, 2, 3, 4};
      tbl[1] = '{0, 3, 16'h0040, 4'b1000, 16'hC0DE, 1, 1, 2, 3};
      tbl[2] = '{2, 0, 16'h0123, 4'b0001, 16'hBEEF, 1, 3, 4, 5};

      do_reset();

      // Single-request latency table, request raised at cycle 2.
      for (int v = 0; v < 3; v++) begin
         do_reset();
         raise_at[tbl[v].port]   = 2;
         raise_addr[tbl[v].port] = tbl[v].addr;
         repeat (12) cycle(tbl[v].inst);
         check($sformatf("v%0d_en_off", v),   32'(en_c - 2),   32'(tbl[v].en_off));
         check($sformatf("v%0d_en_addr", v),  32'((en_addr_q.size() > 0) ? en_addr_q[0] : 16'hFFFF), 32'(tbl[v].addr));
         check($sformatf("v%0d_rdy_off", v),  32'(rdy_c - 2),  32'(tbl[v].rdy_off));
         check($sformatf("v%0d_rdy_val", v),  32'(rdy_v),      32'(tbl[v].rdy));
         check($sformatf("v%0d_dat_off", v),  32'(dat_c - 2),  32'(tbl[v].dat_off));
         check($sformatf("v%0d_dat_val", v),  32'(dat_v),      32'(tbl[v].data));
         check($sformatf("v%0d_idle_off", v), 32'(idle_c - 2), 32'(tbl[v].idle_off));
      end

      // All four ports from reset: served 0,1,2,3.
      do_reset();
      for (int p = 0; p < NP; p++) begin
         raise_at[p]   = 0;
         raise_addr[p] = 16'(16'h1000 + p * 16'h0011);
      end
      repeat (20) cycle(1);
      check_order("order_all", 0, 1, 2, 3, 4);

      // Port 1 served, then 0 and 1 together: scan 2,3,0 picks 0.
      do_reset();
      raise_at[1] = 0; raise_addr[1] = 16'h2222;
      repeat (6) cycle(1);
      raise_at[0] = 6; raise_addr[0] = 16'h2000;
      raise_at[1] = 6; raise_addr[1] = 16'h2333;
      repeat (16) cycle(1);
      check_order("order_after1", 1, 0, 1, 0, 3);

      // Port 1 re-raises with a new address the cycle after its data.
      do_reset();
      raise_at[1] = 0; raise_addr[1] = 16'h0300;
      repeat (4) cycle(1);
      raise_at[1] = 4; raise_addr[1] = 16'h0456;
      repeat (8) cycle(1);
      check("reraise_en_count", 32'(en_cyc_q.size()), 32'd2);
      check("reraise_en_cycle", 32'((en_cyc_q.size() > 1) ? en_cyc_q[1] : -1), 32'd5);
      check("reraise_en_addr",  32'((en_addr_q.size() > 1) ? en_addr_q[1] : 16'hFFFF), 32'h0456);

      // Reset during S_WAIT at latency 3: outputs clear at once, no ready.
      do_reset();
      raise_at[1] = 0; raise_addr[1] = 16'h0777;
      repeat (3) cycle(2);
      check("mid_busy_before_reset", 32'(bsy[2]), 32'd1);
      do_reset();
      raise_at[0] = 0; raise_addr[0] = 16'h0A00;
      raise_at[2] = 0; raise_addr[2] = 16'h0A02;
      repeat (14) cycle(2);
      check_order("order_post_reset", 0, 2, 0, 0, 2);

      // Randomized traffic against the reference at each latency.
      for (int i = 0; i < NI; i++) begin
         do_reset();
         rnd = 1'b1;
         repeat (300) cycle(i);
         rnd = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
